insulin_dose_controller: RTL and testbench

- Downstream consumer of the glycemic index calculator. Takes the 4-bit glycemicIndex plus a sample strobe and decides whether to command an insulin dose or raise a hypoglycaemia alarm.
- Confirms high readings over consecutive samples before dosing. Runs a valid/ready-style request handshake with the pump actuator, then enforces a cooldown.
- Sits between the index calculator and the pump driver / alarm LED logic.

---
 rtl/glycemic_pkg.sv | 21 ++
 rtl/insulin_dose_controller_if.sv | 26 ++
 rtl/gi_classifier.sv | 27 ++
 rtl/insulin_dose_controller.sv | 140 ++++++++++++++
 tb/tb_insulin_dose_controller.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/glycemic_pkg.sv
// Shared types and constants for the glycemic index calculator and the
// insulin dose controller.
package glycemic_pkg;

  // Index and dose bus widths
  localparam int GI_W   = 4;
  localparam int DOSE_W = 4;

  // Default classification thresholds, shared with the index calculator bench
  localparam int DEFAULT_HIGH_TH = 10;
  localparam int DEFAULT_LOW_TH  = 3;

  // Dose controller states
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DOSE     = 2'd1,
    COOLDOWN = 2'd2,
    FAULT    = 2'd3
  } dose_state_t;

endpackage

// File: rtl/insulin_dose_controller_if.sv
// Sample input, pump handshake and status signals of the insulin dose
// controller. The master side is the controller itself; the slave side is
// the index source plus the pump driver / alarm logic.
interface insulin_dose_controller_if;
  import glycemic_pkg::*;

  logic [GI_W-1:0]   glycemicIndex;
  logic              sampleValid;
  logic              pumpReady;
  logic              doseRequest;
  logic [DOSE_W-1:0] doseUnits;
  logic              alarm;
  logic              pumpFault;
  logic              busy;

  modport master (
    input  glycemicIndex, sampleValid, pumpReady,
    output doseRequest, doseUnits, alarm, pumpFault, busy
  );

  modport slave (
    output glycemicIndex, sampleValid, pumpReady,
    input  doseRequest, doseUnits, alarm, pumpFault, busy
  );

endinterface

// File: rtl/gi_classifier.sv
// Combinational classifier: flags high/low samples and computes the capped
// dose size for a high sample.
module gi_classifier
  import glycemic_pkg::*;
#(
  parameter int MAX_DOSE = 4
) (
  input  logic [GI_W-1:0]   glycemicIndex,
  input  logic [GI_W-1:0]   highTh,
  input  logic [GI_W-1:0]   lowTh,
  output logic              isHigh,
  output logic              isLow,
  output logic [DOSE_W-1:0] rawDose
);

  // One extra bit so GI - HIGH_TH + 1 cannot overflow before the cap.
  // Below HIGH_TH the difference wraps large and simply caps; the result
  // is only used for high samples anyway.
  logic [GI_W:0] dose_wide;

  assign dose_wide = {1'b0, glycemicIndex} - {1'b0, highTh} + (GI_W+1)'(1);
  assign isHigh    = (glycemicIndex >= highTh);
  assign isLow     = (glycemicIndex <= lowTh);
  assign rawDose   = (dose_wide > (GI_W+1)'(MAX_DOSE)) ? DOSE_W'(MAX_DOSE)
                                                       : dose_wide[DOSE_W-1:0];

endmodule

// File: rtl/insulin_dose_controller.sv
// Insulin dose controller: confirms high glycemic readings over consecutive
// samples, requests a dose from the pump with an ack timeout, then cools
// down. Low readings raise the hypoglycaemia alarm in every state but DOSE.
module insulin_dose_controller
  import glycemic_pkg::*;
#(
  parameter int HIGH_TH      = DEFAULT_HIGH_TH,
  parameter int LOW_TH       = DEFAULT_LOW_TH,
  parameter int CONFIRM_CNT  = 3,
  parameter int MAX_DOSE     = 4,
  parameter int COOLDOWN_CYC = 64,
  parameter int ACK_TIMEOUT  = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  insulin_dose_controller_if.master  bus
);

  // Counters only ever reach their limit minus one
  localparam int TO_W = (ACK_TIMEOUT  > 1) ? $clog2(ACK_TIMEOUT)  : 1;
  localparam int CD_W = (COOLDOWN_CYC > 1) ? $clog2(COOLDOWN_CYC) : 1;
  localparam logic [3:0]      CONFIRM_TARGET = 4'(CONFIRM_CNT);
  localparam logic [TO_W-1:0] TO_LAST        = TO_W'(ACK_TIMEOUT - 1);
  localparam logic [CD_W-1:0] CD_LAST        = CD_W'(COOLDOWN_CYC - 1);

  dose_state_t       state;
  logic [3:0]        confirm_cnt;
  logic [3:0]        confirm_inc;
  logic [TO_W-1:0]   timeout_cnt;
  logic [CD_W-1:0]   cool_cnt;
  logic              dose_request;
  logic [DOSE_W-1:0] dose_units;
  logic              alarm;
  logic              pump_fault;
  logic              busy;
  logic              is_high;
  logic              is_low;
  logic [DOSE_W-1:0] raw_dose;

  gi_classifier #(
    .MAX_DOSE (MAX_DOSE)
  ) u_classifier (
    .glycemicIndex (bus.glycemicIndex),
    .highTh        (GI_W'(HIGH_TH)),
    .lowTh         (GI_W'(LOW_TH)),
    .isHigh        (is_high),
    .isLow         (is_low),
    .rawDose       (raw_dose)
  );

  // Saturating next value of the consecutive-high counter
  assign confirm_inc = (confirm_cnt == 4'hF) ? 4'hF : confirm_cnt + 4'd1;

  // Controller FSM with registered outputs, counters and timers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      confirm_cnt  <= '0;
      timeout_cnt  <= '0;
      cool_cnt     <= '0;
      dose_request <= 1'b0;
      dose_units   <= '0;
      alarm        <= 1'b0;
      pump_fault   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.sampleValid) begin
            if (is_low) begin
              alarm       <= 1'b1;
              confirm_cnt <= '0;
            end else if (is_high) begin
              alarm <= 1'b0;
              if (confirm_inc == CONFIRM_TARGET) begin
                state        <= DOSE;
                dose_request <= 1'b1;
                dose_units   <= raw_dose;
                busy         <= 1'b1;
                confirm_cnt  <= '0;
                timeout_cnt  <= '0;
              end else begin
                confirm_cnt <= confirm_inc;
              end
            end else begin
              alarm       <= 1'b0;
              confirm_cnt <= '0;
            end
          end
        end

        DOSE: begin
          // An ack on the timeout edge still counts as a completed dose
          if (bus.pumpReady) begin
            state        <= COOLDOWN;
            dose_request <= 1'b0;
            dose_units   <= '0;
            cool_cnt     <= '0;
          end else if (timeout_cnt == TO_LAST) begin
            state        <= FAULT;
            dose_request <= 1'b0;
            dose_units   <= '0;
            busy         <= 1'b0;
            pump_fault   <= 1'b1;
          end else begin
            timeout_cnt <= timeout_cnt + TO_W'(1);
          end
        end

        COOLDOWN: begin
          // Dosing is suppressed, but the alarm keeps tracking samples
          if (bus.sampleValid) begin
            alarm <= is_low;
          end
          if (cool_cnt == CD_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cool_cnt <= cool_cnt + CD_W'(1);
          end
        end

        FAULT: begin
          if (bus.sampleValid) begin
            alarm <= is_low;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.doseRequest = dose_request;
  assign bus.doseUnits   = dose_units;
  assign bus.alarm       = alarm;
  assign bus.pumpFault   = pump_fault;
  assign bus.busy        = busy;

endmodule

// File: tb/tb_insulin_dose_controller.sv
// Directed self-checking bench for insulin_dose_controller with default
// parameters (HIGH_TH=10, LOW_TH=3, CONFIRM_CNT=3, MAX_DOSE=4,
// COOLDOWN_CYC=64, ACK_TIMEOUT=32).
module tb_insulin_dose_controller;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  int   n;

  insulin_dose_controller_if bus_if();

  insulin_dose_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for every check in the bench
  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Advance one clock; outputs are observed 1ns after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one sample for exactly one edge
  task automatic send_sample(input int gi);
    bus_if.glycemicIndex = 4'(gi);
    bus_if.sampleValid   = 1'b1;
    tick();
    bus_if.sampleValid   = 1'b0;
    $display("sample gi=%0d pumpReady=%0b -> req=%0b units=%0d alarm=%0b busy=%0b fault=%0b",
             gi, bus_if.pumpReady, bus_if.doseRequest, bus_if.doseUnits,
             bus_if.alarm, bus_if.busy, bus_if.pumpFault);
  endtask

  // Count cycles until busy drops, bounded
  task automatic wait_not_busy(output int cycles);
    cycles = 0;
    while (bus_if.busy && cycles < 200) begin
      tick();
      cycles++;
    end
  endtask

  initial begin
    n_checks             = 0;
    n_fail               = 0;
    reset                = 1'b1;
    bus_if.glycemicIndex = '0;
    bus_if.sampleValid   = 1'b0;
    bus_if.pumpReady     = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_req",   32'(bus_if.doseRequest), 0);
    check("rst_units", 32'(bus_if.doseUnits),   0);
    check("rst_alarm", 32'(bus_if.alarm),       0);
    check("rst_fault", 32'(bus_if.pumpFault),   0);
    check("rst_busy",  32'(bus_if.busy),        0);
    reset = 1'b0;
    tick();

    // Reset mid-DOSE drops everything at once; no retry afterwards
    send_sample(12);
    send_sample(12);
    send_sample(12);
    check("pre_rst_req",   32'(bus_if.doseRequest), 1);
    check("pre_rst_units", 32'(bus_if.doseUnits),   3);
    tick();
    reset = 1'b1;
    #1;
    check("async_rst_req",   32'(bus_if.doseRequest), 0);
    check("async_rst_units", 32'(bus_if.doseUnits),   0);
    check("async_rst_busy",  32'(bus_if.busy),        0);
    tick();
    reset = 1'b0;
    send_sample(12);
    check("post_rst_single", 32'(bus_if.doseRequest), 0);
    tick();
    tick();
    check("post_rst_noretry", 32'(bus_if.doseRequest), 0);
    send_sample(7);
    check("normal_alarm", 32'(bus_if.alarm), 0);

    // Three highs with the pump ready: single-cycle request, 64-cycle cooldown
    bus_if.pumpReady = 1'b1;
    send_sample(12);
    check("h1_req", 32'(bus_if.doseRequest), 0);
    send_sample(12);
    check("h2_req", 32'(bus_if.doseRequest), 0);
    send_sample(12);
    check("h3_req",   32'(bus_if.doseRequest), 1);
    check("h3_units", 32'(bus_if.doseUnits),   3);
    check("h3_busy",  32'(bus_if.busy),        1);
    tick();
    check("ack_req",   32'(bus_if.doseRequest), 0);
    check("ack_units", 32'(bus_if.doseUnits),   0);
    check("cool_busy", 32'(bus_if.busy),        1);
    wait_not_busy(n);
    check("cool_len", 32'(n), 64);
    check("cool_fault", 32'(bus_if.pumpFault), 0);

    // Normal sample breaks the high run; alarm tracking during cooldown
    send_sample(12);
    send_sample(7);
    send_sample(12);
    send_sample(12);
    check("broken_run_req", 32'(bus_if.doseRequest), 0);
    send_sample(12);
    check("run5_req",   32'(bus_if.doseRequest), 1);
    check("run5_units", 32'(bus_if.doseUnits),   3);
    tick();
    n = 0;
    send_sample(2);
    n++;
    check("cool_low_alarm", 32'(bus_if.alarm), 1);
    send_sample(5);
    n++;
    check("cool_norm_alarm", 32'(bus_if.alarm), 0);
    while (bus_if.busy && n < 200) begin
      tick();
      n++;
    end
    check("cool_len_samples", 32'(n), 64);

    // Boundary thresholds and minimum dose
    send_sample(3);
    check("low_th_alarm", 32'(bus_if.alarm), 1);
    send_sample(4);
    check("above_low_alarm", 32'(bus_if.alarm), 0);
    send_sample(9);
    send_sample(9);
    send_sample(9);
    check("below_high_req", 32'(bus_if.doseRequest), 0);
    send_sample(10);
    send_sample(10);
    send_sample(10);
    check("gi10_req",   32'(bus_if.doseRequest), 1);
    check("gi10_units", 32'(bus_if.doseUnits),   1);
    tick();
    wait_not_busy(n);
    check("gi10_cool_len", 32'(n), 64);

    // Ack arriving on the 32nd DOSE cycle wins over the timeout
    bus_if.pumpReady = 1'b0;
    send_sample(12);
    send_sample(12);
    send_sample(12);
    check("late_req", 32'(bus_if.doseRequest), 1);
    for (int i = 0; i < 31; i++) tick();
    check("late_req_held", 32'(bus_if.doseRequest), 1);
    bus_if.pumpReady = 1'b1;
    tick();
    bus_if.pumpReady = 1'b0;
    check("late_ack_req",   32'(bus_if.doseRequest), 0);
    check("late_ack_busy",  32'(bus_if.busy),        1);
    check("late_ack_fault", 32'(bus_if.pumpFault),   0);
    wait_not_busy(n);
    check("late_cool_len", 32'(n), 64);

    // No ack: request held 32 cycles, then sticky fault
    send_sample(15);
    send_sample(15);
    send_sample(15);
    check("to_req",   32'(bus_if.doseRequest), 1);
    check("to_units", 32'(bus_if.doseUnits),   4);
    n = 0;
    while (bus_if.doseRequest && n < 100) begin
      tick();
      n++;
    end
    check("to_req_len", 32'(n), 32);
    check("to_fault",   32'(bus_if.pumpFault), 1);
    check("to_busy",    32'(bus_if.busy),      0);
    send_sample(2);
    check("fault_low_alarm", 32'(bus_if.alarm),       1);
    check("fault_low_req",   32'(bus_if.doseRequest), 0);
    bus_if.pumpReady = 1'b1;
    send_sample(12);
    send_sample(12);
    send_sample(12);
    check("fault_no_dose",   32'(bus_if.doseRequest), 0);
    check("fault_hi_alarm",  32'(bus_if.alarm),       0);
    check("fault_sticky",    32'(bus_if.pumpFault),   1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
